// File: rtl/adc_serial_sampler.sv
// adc_serial_sampler
//   Drives an 8-bit-class serial ADC and presents parallel samples.
//   It generates CS_N and SCLK from CLK and shifts in each word MSB first.
//   Completed words appear on SampleOUT together with a one-cycle SampleValid.
//   While Enable is held, conversions repeat every
//   2*CLK_DIV*WIDTH + SAMPLE_GAP cycles.
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   Enable      request continuous conversions
//   ADC_MISO    serial data from the ADC (changes after SCLK falling edges)
//   ADC_CS_N    active-low chip select (registered)
//   ADC_SCLK    serial clock, idles low (registered)
//   SampleOUT   last completed sample, held until the next completion
//   SampleValid one-cycle pulse when SampleOUT updates
//   Busy        high whenever the FSM is not in IDLE
module adc_serial_sampler #(
  parameter int WIDTH      = 8,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_GAP = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Enable,
  input  logic             ADC_MISO,
  output logic             ADC_CS_N,
  output logic             ADC_SCLK,
  output logic [WIDTH-1:0] SampleOUT,
  output logic             SampleValid,
  output logic             Busy
);

  localparam int BIT_W  = $clog2(WIDTH + 1);
  localparam int HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W  = $clog2(SAMPLE_GAP + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  state_t            state;
  logic [HALF_W-1:0] halfCnt;
  logic [BIT_W-1:0]  bitCnt;
  logic [GAP_W-1:0]  gapCnt;
  logic [WIDTH-1:0]  shiftReg;

  logic halfEnd, lastBit, gapEnd;

  always_comb begin
    halfEnd = (halfCnt == HALF_W'(CLK_DIV - 1));
    lastBit = (bitCnt == BIT_W'(WIDTH - 1));
    // gapCnt counts CS-high cycles already spent; DONE is the first with gapCnt=0
    gapEnd  = (gapCnt == GAP_W'(SAMPLE_GAP - 1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      halfCnt     <= '0;
      bitCnt      <= '0;
      gapCnt      <= '0;
      shiftReg    <= '0;
      ADC_CS_N    <= 1'b1;
      ADC_SCLK    <= 1'b0;
      SampleOUT   <= '0;
      SampleValid <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      SampleValid <= 1'b0;
      case (state)
        IDLE: begin
          if (Enable) begin
            state    <= SHIFT;
            ADC_CS_N <= 1'b0;
            Busy     <= 1'b1;
            halfCnt  <= '0;
            bitCnt   <= '0;
          end
        end

        SHIFT: begin
          if (halfEnd) begin
            halfCnt <= '0;
            if (!ADC_SCLK) begin
              // Rising SCLK: capture into LSB so the first bit ends in the MSB
              ADC_SCLK <= 1'b1;
              shiftReg <= (shiftReg << 1) | WIDTH'(ADC_MISO);
            end else begin
              ADC_SCLK <= 1'b0;
              if (lastBit) begin
                // Publish on the same edge CS_N rises so SampleValid marks DONE
                state       <= DONE;
                ADC_CS_N    <= 1'b1;
                SampleOUT   <= shiftReg;
                SampleValid <= 1'b1;
              end else begin
                bitCnt <= bitCnt + BIT_W'(1);
              end
            end
          end else begin
            halfCnt <= halfCnt + HALF_W'(1);
          end
        end

        // DONE shares the gap countdown so SAMPLE_GAP=1 exits straight from DONE
        DONE, GAP: begin
          if (gapEnd) begin
            gapCnt <= '0;
            if (Enable) begin
              state    <= SHIFT;
              ADC_CS_N <= 1'b0;
              halfCnt  <= '0;
              bitCnt   <= '0;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end else begin
            state  <= GAP;
            gapCnt <= gapCnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/adc_serial_sampler.md
# adc_serial_sampler

Front-end acquisition stage that drives an 8-bit serial ADC (chip-select, serial clock, data-out line) and produces parallel samples for the 4-sample averaging stage directly downstream. It generates CS and SCLK from the system clock and shifts in one conversion MSB first. Each completed word is presented on `SampleOUT` with a one-cycle `SampleValid` strobe. While `Enable` is held, conversions repeat at a fixed, parameter-defined rate.

## Interface
Parameters:
- `WIDTH`, default 8: bits per conversion, which is also the `SampleOUT` width.
- `CLK_DIV`, default 4: `CLK` cycles per SCLK half-period. Must be ≥1.
- `SAMPLE_GAP`, default 16: `CLK` cycles with CS deasserted between conversions. Must be ≥1.

Ports:
- `CLK`, input, 1 bit: system clock. All logic is on the rising edge.
- `RST`, input, 1 bit: synchronous, active-high reset.
- `Enable`, input, 1 bit: request continuous conversions.
- `ADC_MISO`, input, 1 bit: serial data from the ADC. It changes after SCLK falling edges.
- `ADC_CS_N`, output, 1 bit: active-low chip select.
- `ADC_SCLK`, output, 1 bit: serial clock to the ADC. It idles low.
- `SampleOUT`, output, WIDTH bits: last completed sample. Held until the next completion.
- `SampleValid`, output, 1 bit: one-cycle pulse when `SampleOUT` updates.
- `Busy`, output, 1 bit: high whenever the FSM is not in IDLE.

## Operation
- **Clock and reset:** one clock domain. Reset is synchronous and active-high on `RST`.
- **Reset values:** `ADC_CS_N`=1, `ADC_SCLK`=0, `SampleOUT`=0, `SampleValid`=0, `Busy`=0. FSM is in IDLE; all counters and the shift register are 0.
- **FSM states:** IDLE, SHIFT, DONE, GAP.
- **IDLE:**
  - Outputs: CS_N=1, SCLK=0.
  - On the edge where `Enable`=1, go to SHIFT. CS_N goes low and the half-period counter and bit counter are cleared.
- **SHIFT:**
  - SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles. This repeats WIDTH times.
  - On each CLK edge that drives SCLK 0→1, `ADC_MISO` is shifted into the LSB of the shift register, so the first bit captured ends in the MSB.
  - After the WIDTH-th high half-period the FSM goes to DONE on that edge. SCLK returns to 0 and CS_N returns to 1 on the same edge.
- **DONE:** a single cycle.
  - `SampleOUT` takes the shift register and `SampleValid`=1 for exactly this cycle.
  - Next state is GAP.
- **GAP:**
  - CS_N=1 and SCLK=0 for SAMPLE_GAP cycles in total, counting DONE as the first.
  - At the end of GAP: if `Enable`=1, go to SHIFT (CS_N low); otherwise go to IDLE.
- **Enable handling:**
  - `Enable` is sampled only in IDLE and at the end of GAP.
  - Deasserting `Enable` during SHIFT does not abort the conversion. It completes and produces a valid sample.
- **Reset mid-operation:** `RST` in any state forces the reset values on the next edge. A partial word is discarded and no `SampleValid` is generated.
- **Width rules:**
  - Bit counter width is clog2(WIDTH+1).
  - Half-period counter width is clog2(CLK_DIV), minimum 1 bit.
  - GAP counter width is clog2(SAMPLE_GAP+1).
  - No arithmetic is performed on sample data.

## Timing
- **CS low time:** CS_N is low for exactly 2·CLK_DIV·WIDTH cycles per conversion. This is 64 cycles with the defaults.
- **Rising SCLK edges:** exactly WIDTH per conversion.
  - The first occurs CLK_DIV cycles after CS_N falls.
  - Later ones are spaced 2·CLK_DIV cycles apart.
- **Latency:** `SampleValid` asserts in the cycle where CS_N returns high. That is 2·CLK_DIV·WIDTH cycles after CS_N fell.
- **Continuous-mode period:** 2·CLK_DIV·WIDTH + SAMPLE_GAP cycles per sample. This is 80 cycles with the defaults, and `SampleValid` pulses are exactly that far apart.
- **First CS fall:** on the edge where IDLE samples `Enable`=1.
- **Busy:** rises on that same edge and falls on the edge where GAP exits to IDLE.
- **Glitch-free outputs:** `ADC_CS_N` and `ADC_SCLK` are driven directly from registers.
- **Edge case CLK_DIV=1:** SCLK toggles every cycle, giving a 2-cycle period. Bit capture and all counts still hold.

## Test plan
- **Reset:**
  - Stimulus: hold `RST` for 3 cycles with `Enable`=1 and `ADC_MISO`=1.
  - Required: CS_N=1, SCLK=0, `SampleOUT`=0x00, `SampleValid`=0, `Busy`=0 throughout. CS_N falls on the first edge after `RST` is released.
- **Single conversion:**
  - Stimulus: `Enable` high for one cycle; an ADC model drives 0xA5 MSB first on SCLK falling edges.
  - Required: exactly 8 SCLK rising edges, CS_N low for exactly 64 cycles, `SampleOUT`=0xA5, exactly one `SampleValid` pulse, then IDLE 16 cycles later.
- **Continuous mode:**
  - Stimulus: `Enable` held high; the ADC model returns 0x00, 0xFF, 0x3C.
  - Required: `SampleValid` pulses exactly 80 cycles apart with `SampleOUT` = 0x00, 0xFF, 0x3C in order.
- **Enable drop mid-conversion:**
  - Stimulus: deassert `Enable` at bit 3 of a 0x5A conversion.
  - Required: the conversion completes with `SampleOUT`=0x5A and one pulse, then no further CS_N fall.
- **Reset mid-conversion:**
  - Stimulus: assert `RST` after 4 bits have been captured.
  - Required: CS_N=1, SCLK=0, and `SampleOUT`=0 on the next edge, with no `SampleValid`. A following conversion of 0x81 completes correctly.
- **CLK_DIV=1 instance:**
  - Stimulus: an instance with `CLK_DIV`=1 and `SAMPLE_GAP`=1 under continuous `Enable`, ADC model returning 0x81 then 0x7E.
  - Required: CS_N low for 16 cycles, `SampleValid` period of 17 cycles, and samples 0x81 then 0x7E.
